spi_reg_ctrl: RTL
=================

SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 Parameter: DEV_ID, 8'hA5, read-only identification byte returned at address 0x7F.
REQ-002 Parameter: AUTO_INC, 1'b1, 1 = address post-increments after each data byte; 0 = address held for the whole frame.
REQ-003 Port: sys_clk  input  1  system clock; all logic on rising edge.
REQ-004 Port: sys_rst  input  1  asynchronous, active-high reset.
REQ-005 Port: cs  input  1  SPI chip select from the pin, active-low, asynchronous to sys_clk.
REQ-006 Port: rx_valid  input  1  one-cycle strobe from the SPI slave; rx_data holds a complete byte.
REQ-007 Port: rx_data  input  8  received byte, valid while rx_valid=1.
REQ-008 Port: tx_data  output  8  byte to be shifted out on the next SPI byte slot.
REQ-009 Port: status_in  input  64  eight read-only status bytes; byte k = status_in[8k+7:8k], mapped at address 0x08+k.
REQ-010 Port: reg_out  output  64  eight read/write control bytes; byte k = reg_out[8k+7:8k], mapped at address 0x00+k.
REQ-011 Port: wr_strobe  output  1  one-cycle pulse when a control register is written.
REQ-012 Port: wr_addr  output  3  index of the register written, valid while wr_strobe=1.
REQ-013 Port: err_cnt  output  8  count of illegal accesses, saturating.

Function
REQ-014 The block SHALL synchronise cs through 2 flops (cs_s); frame active while cs_s=0.
REQ-015 A frame SHALL be: byte 0 = command {rw, addr[6:0]} (rw=1 read, 0 write), followed by bytes 1..N = data.
REQ-016 FSM states: IDLE, CMD, WDATA, RDATA.
REQ-017 IDLE->CMD when cs_s=0.
REQ-018 CMD->WDATA or RDATA on rx_valid, by rw bit; the address register SHALL be loaded with addr[6:0].
REQ-019 WDATA/RDATA SHALL hold until cs_s=1.
REQ-020 Any state -> IDLE when cs_s=1; rx_valid in IDLE SHALL be ignored.
REQ-021 If rx_valid coincides with cs_s rising, the byte SHALL be fully processed in that cycle and the next state SHALL be IDLE.
REQ-022 Write, WDATA + rx_valid, address 0x00-0x07: the register SHALL be updated on the next edge; wr_strobe=1 and wr_addr=addr[2:0] for exactly that cycle.
REQ-023 Write to 0x08-0x0F, 0x7F or any unmapped address: no register change, no wr_strobe, err_cnt+1.
REQ-024 Read, RDATA entry and each RDATA rx_valid: tx_data SHALL present the byte at the current address, registered, no later than 2 sys_clk cycles after the rx_valid.
REQ-025 Read map: 0x00-0x07 -> reg_out byte; 0x08-0x0F -> status_in byte sampled at that moment; 0x7F -> DEV_ID; unmapped -> 8'h00 with err_cnt+1.
REQ-026 With AUTO_INC=1, the address SHALL increment after every data byte, wrapping 0x7F->0x00 within 7 bits.
REQ-027 For reads, the address SHALL increment after each byte is loaded into tx_data, so byte n of a read frame returns addr+n-1.
REQ-028 In CMD, WDATA and IDLE, tx_data SHALL be 8'h00.
REQ-029 err_cnt SHALL saturate at 8'hFF and is cleared only by reset.
REQ-030 A frame of cmd only (cs_s rising after byte 0) SHALL change no register and SHALL NOT touch err_cnt.

Reset
REQ-031 While sys_rst=1, the following SHALL be held asynchronously: state=IDLE, reg_out=64'h0, tx_data=8'h00, wr_strobe=0, wr_addr=3'd0, err_cnt=8'h00, address=7'h00, cs sync flops=1.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no partial write.
REQ-033 After reset release, the block SHALL wait for cs_s=1 before accepting a new frame.

Verification
REQ-034 Reset, then frame {0x02, 0x3C}: reg_out[23:16]=0x3C, one wr_strobe with wr_addr=2, err_cnt=0.
REQ-035 AUTO_INC=1, frame {0x06, 0x11, 0x22, 0x33}: reg6=0x11, reg7=0x22; write to 0x08 rejected; err_cnt=1; 2 wr_strobes.
REQ-036 status_in byte1=0x5A, frame {0x89, x, x}: tx_data=0x5A during byte 2, then status byte2 during byte 3.
REQ-037 Frame {0xFF, x, x}: tx_data=0xA5, then address wraps to 0x00 and returns reg0.
REQ-038 err_cnt preset to 255 via illegal writes, then one more illegal write: err_cnt stays 0xFF.
REQ-039 cs raised after 0x01, and separately sys_rst pulsed mid-WDATA: no write occurs, state=IDLE, next frame works normally.

Source files
------------

// File: rtl/spi_reg_ctrl.sv
// SPI register slave: command byte then data bytes into 8 control regs, 8 status bytes, ID byte.
// Latency: 1 sys_clk from rx_valid to register/tx_data update; no backpressure, every rx_valid byte is consumed.
module spi_reg_ctrl #(
    parameter logic [7:0] DEV_ID   = 8'hA5,
    parameter bit         AUTO_INC = 1'b1
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        cs,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic [7:0]  tx_data,
    input  logic [63:0] status_in,
    output logic [63:0] reg_out,
    output logic        wr_strobe,
    output logic [2:0]  wr_addr,
    output logic [7:0]  err_cnt
);

    typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

    state_t      state, state_n;
    logic        cs_q1, cs_s;
    logic [1:0]  sync_ok;
    logic        armed;
    logic [6:0]  addr, addr_n, addr_nxt, rd_addr;
    logic [7:0]  tx_n, rd_dat;
    logic        tx_err, tx_err_n, rd_err;
    logic [63:0] reg_n;
    logic        stb_n, err_inc;
    logic [2:0]  wa_n;

    // armed only once a genuine (post-reset) cs_s high has been seen, so a frame in progress is skipped
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cs_q1   <= 1'b1;
            cs_s    <= 1'b1;
            sync_ok <= 2'b00;
            armed   <= 1'b0;
        end else begin
            cs_q1   <= cs;
            cs_s    <= cs_q1;
            sync_ok <= {sync_ok[0], 1'b1};
            if (cs_s && sync_ok[1])
                armed <= 1'b1;
        end
    end

    assign rd_addr  = (state == CMD) ? rx_data[6:0] : addr;
    assign addr_nxt = AUTO_INC ? rd_addr + 7'd1 : rd_addr;

    always_comb begin
        rd_dat = 8'h00;
        rd_err = 1'b0;
        if (rd_addr[6:3] == 4'h0)
            rd_dat = reg_out[{rd_addr[2:0], 3'b000} +: 8];
        else if (rd_addr[6:3] == 4'h1)
            rd_dat = status_in[{rd_addr[2:0], 3'b000} +: 8];
        else if (rd_addr == 7'h7F)
            rd_dat = DEV_ID;
        else
            rd_err = 1'b1;
    end

    // read errors are charged when the byte is actually clocked out, so a trailing prefetch is free
    always_comb begin
        state_n  = state;
        addr_n   = addr;
        tx_n     = tx_data;
        tx_err_n = tx_err;
        reg_n    = reg_out;
        stb_n    = 1'b0;
        wa_n     = wr_addr;
        err_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (!cs_s && armed)
                    state_n = CMD;
            end
            CMD: begin
                if (rx_valid) begin
                    addr_n = rx_data[6:0];
                    if (rx_data[7]) begin
                        tx_n     = rd_dat;
                        tx_err_n = rd_err;
                        addr_n   = addr_nxt;
                        state_n  = RDATA;
                    end else begin
                        state_n = WDATA;
                    end
                end
            end
            WDATA: begin
                if (rx_valid) begin
                    if (addr[6:3] == 4'h0) begin
                        reg_n[{addr[2:0], 3'b000} +: 8] = rx_data;
                        stb_n = 1'b1;
                        wa_n  = addr[2:0];
                    end else begin
                        err_inc = 1'b1;
                    end
                    addr_n = addr_nxt;
                end
            end
            RDATA: begin
                if (rx_valid) begin
                    err_inc  = tx_err;
                    tx_n     = rd_dat;
                    tx_err_n = rd_err;
                    addr_n   = addr_nxt;
                end
            end
            default: state_n = IDLE;
        endcase
        if (cs_s)
            state_n = IDLE;
        if (state_n != RDATA) begin
            tx_n     = 8'h00;
            tx_err_n = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= IDLE;
            addr      <= 7'h00;
            tx_data   <= 8'h00;
            tx_err    <= 1'b0;
            reg_out   <= 64'h0;
            wr_strobe <= 1'b0;
            wr_addr   <= 3'd0;
            err_cnt   <= 8'h00;
        end else begin
            state     <= state_n;
            addr      <= addr_n;
            tx_data   <= tx_n;
            tx_err    <= tx_err_n;
            reg_out   <= reg_n;
            wr_strobe <= stb_n;
            wr_addr   <= wa_n;
            if (err_inc && (err_cnt != 8'hFF))
                err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule
